alu_1bit: RTL and testbench
===========================

// Module: alu_1bit
// PURPOSE
//   One-bit ALU slice for the 16-bit CPU datapath; sixteen instances ripple-chain via cin/cout.
//   Per bit it computes AND/OR/XOR/ADD/LESS on optionally inverted operands.
//   Supports MIPS-style subtract (bnegate=1, cin=1 at LSB) and set-less-than (less/set).
//   Outputs are registered once per clock.
// PARAMETERS
//   None.
// PORTS
//   clk      in   1  system clock; all state updates on rising edge
//   reset    in   1  synchronous, active-high reset
//   a        in   1  operand A bit
//   b        in   1  operand B bit
//   cin      in   1  carry in from the lower slice (or the subtract flag at the LSB)
//   ainvert  in   1  1: use ~a in every operation
//   bnegate  in   1  1: use ~b in every operation
//   op       in   3  operation select (see BEHAVIOUR)
//   less     in   1  value passed through for op=101 (set from the MSB slice, else 0)
//   result   out  1  registered operation result
//   cout     out  1  registered adder carry out
//   set      out  1  registered adder sum bit (used at the MSB to feed less of bit 0)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. No asynchronous state.
//   - Operand conditioning (combinational):
//     - aa = a ^ ainvert
//     - bb = b ^ bnegate
//     - sum = aa ^ bb ^ cin
//     - carry = (aa&bb) | (aa&cin) | (bb&cin)
//   - Operation decode:
//     - 000: aa & bb (AND)
//     - 010: aa | bb (OR)
//     - 110: aa ^ bb (XOR)
//     - 100: sum (ADD/SUB)
//     - 101: less (SLT pass-through)
//     - All other codes (001, 011, 111): result 0.
//   - cout and set always reflect carry and sum, whatever op is selected.
//   - Latency: exactly 1 cycle. Inputs sampled at edge N appear on result/cout/set after edge N.
//     Values hold until the next edge.
//   - reset=1 at an edge: result=0, cout=0, set=0. Reset overrides all inputs, including mid-operation.
//     The first valid output is one edge after reset deasserts.
//   - X/Z inputs are not handled specially. The bench drives defined values only.
//   - No saturation or overflow logic; overflow detection belongs to the MSB wrapper.
// TESTING
//   - Reset: reset=1 with a=b=1, op=010 -> after edge result=0, cout=0, set=0. Deassert, next edge -> result=1.
//   - AND table: ainvert=bnegate=cin=0, op=000; ab=00,01,10,11 -> result 0,0,0,1, one cycle late.
//   - OR and XOR tables, op=010 and op=110:
//     - ab=00,01,10,11 -> OR result 0,1,1,1
//     - ab=00,01,10,11 -> XOR result 0,1,1,0
//   - ADD, op=100:
//     - a=1, b=1, cin=1 -> result=1, cout=1
//     - a=1, b=0, cin=0 -> result=1, cout=0
//     - set mirrors result in both cases.
//   - SUB and NOR:
//     - op=100, a=0, b=1, bnegate=1, cin=1 -> result=1, cout=0
//     - op=000, ainvert=bnegate=1, a=b=0 -> result=1 (NOR)
//   - LESS and undefined codes:
//     - op=101, less=1 -> result=1
//     - op=001/011/111 with a=b=1 -> result=0, while cout still follows carry.

Source files
------------

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND/OR/XOR/ADD/SLT on optionally inverted operands.
// Sixteen slices ripple through cin/cout; result, cout and set are registered.
module alu_1bit (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       ainvert,
   input  logic       bnegate,
   input  logic [2:0] op,
   input  logic       less,
   output logic       result,
   output logic       cout,
   output logic       set
);

   logic w_aa;
   logic w_bb;
   logic w_sum;
   logic w_carry;
   logic w_result;
   logic r_result;
   logic r_cout;
   logic r_set;

   assign w_aa    = a ^ ainvert;
   assign w_bb    = b ^ bnegate;
   assign w_sum   = w_aa ^ w_bb ^ cin;
   assign w_carry = (w_aa & w_bb) | (w_aa & cin) | (w_bb & cin);

   // Operation select; unused codes drive zero so a stray op cannot leak data.
   always_comb begin
      w_result = 1'b0;
      case (op)
         3'b000:  w_result = w_aa & w_bb;
         3'b010:  w_result = w_aa | w_bb;
         3'b110:  w_result = w_aa ^ w_bb;
         3'b100:  w_result = w_sum;
         3'b101:  w_result = less;
         default: w_result = 1'b0;
      endcase
   end

   // Output registers; cout and set follow the adder regardless of op.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= 1'b0;
         r_cout   <= 1'b0;
         r_set    <= 1'b0;
      end else begin
         r_result <= w_result;
         r_cout   <= w_carry;
         r_set    <= w_sum;
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign set    = r_set;

endmodule

// File: tb/tb_alu_1bit.sv
// Directed bench for alu_1bit: expected values are queued as each step is
// driven and popped one edge later for comparison against the registered outputs.
module tb_alu_1bit;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic       cin;
   logic       ainvert;
   logic       bnegate;
   logic [2:0] op;
   logic       less;
   logic       result;
   logic       cout;
   logic       set;

   typedef struct {
      string tag;
      logic  res;
      logic  cy;
      logic  sm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu_1bit dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .ainvert (ainvert),
      .bnegate (bnegate),
      .op      (op),
      .less    (less),
      .result  (result),
      .cout    (cout),
      .set     (set)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: arithmetic add for sum/carry, truth-level decode for result.
   function automatic exp_t model(input string tag, input logic rst, input logic ia, input logic ib,
                                  input logic icin, input logic iai, input logic ibn,
                                  input logic [2:0] iop, input logic iless);
      exp_t       e;
      logic       aa;
      logic       bb;
      logic [1:0] tot;
      e.tag = tag;
      aa    = iai ? ~ia : ia;
      bb    = ibn ? ~ib : ib;
      tot   = {1'b0, aa} + {1'b0, bb} + {1'b0, icin};
      case (iop)
         3'b000:  e.res = (aa == 1'b1 && bb == 1'b1) ? 1'b1 : 1'b0;
         3'b010:  e.res = (aa == 1'b1 || bb == 1'b1) ? 1'b1 : 1'b0;
         3'b110:  e.res = (aa != bb) ? 1'b1 : 1'b0;
         3'b100:  e.res = tot[0];
         3'b101:  e.res = iless;
         default: e.res = 1'b0;
      endcase
      e.cy = tot[1];
      e.sm = tot[0];
      if (rst) begin
         e.res = 1'b0;
         e.cy  = 1'b0;
         e.sm  = 1'b0;
      end
      return e;
   endfunction

   task automatic step(input string tag, input logic rst, input logic ia, input logic ib,
                       input logic icin, input logic iai, input logic ibn,
                       input logic [2:0] iop, input logic iless);
      exp_t e;
      reset   = rst;
      a       = ia;
      b       = ib;
      cin     = icin;
      ainvert = iai;
      bnegate = ibn;
      op      = iop;
      less    = iless;
      sb.push_back(model(tag, rst, ia, ib, icin, iai, ibn, iop, iless));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (result === e.res) else begin
         errors++;
         $error("FAIL %s.result observed=%b expected=%b", e.tag, result, e.res);
      end
      checks++;
      assert (cout === e.cy) else begin
         errors++;
         $error("FAIL %s.cout observed=%b expected=%b", e.tag, cout, e.cy);
      end
      checks++;
      assert (set === e.sm) else begin
         errors++;
         $error("FAIL %s.set observed=%b expected=%b", e.tag, set, e.sm);
      end
   endtask

   // Directed sequence: reset, logic tables, add/sub, NOR, SLT, unused codes.
   initial begin
      reset = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
      ainvert = 1'b0; bnegate = 1'b0; op = 3'b000; less = 1'b0;

      step("rst",      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
      step("rst_rel",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);

      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = i[1:0];
         step("and", 1'b0, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = i[1:0];
         step("or",  1'b0, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = i[1:0];
         step("xor", 1'b0, ab[1], ab[0], 1'b0, 1'b0, 1'b0, 3'b110, 1'b0);
      end

      step("add111",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
      step("add100",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
      step("sub",      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0);
      step("nor",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
      step("slt1",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b1);
      step("slt0",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0);
      step("op001",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
      step("op011",    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1);
      step("op111",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
      step("rst_mid",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
      step("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);

      // Spot checks against hand-derived constants, independent of the model.
      step("and_hand", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      checks++;
      assert (result === 1'b1 && cout === 1'b1 && set === 1'b0) else begin
         errors++;
         $error("FAIL and_hand.const observed=%b%b%b expected=110", result, cout, set);
      end
      step("sub_hand", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0);
      checks++;
      assert (result === 1'b1 && cout === 1'b0 && set === 1'b1) else begin
         errors++;
         $error("FAIL sub_hand.const observed=%b%b%b expected=101", result, cout, set);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
